// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow clk_in in system-clock cycles, with
// tolerance-based lock detection, stall timeout and a saturating error count.
module clock_period_meter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned EXPECTED   = 50000,
  parameter int unsigned TOL        = 2,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clk_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout,
  output logic [7:0]       err_count
);

  localparam int unsigned StreakW = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;

  localparam logic [WIDTH-1:0]   LoBound     = WIDTH'(EXPECTED - TOL);
  localparam logic [WIDTH-1:0]   HiBound     = WIDTH'(EXPECTED + TOL);
  localparam logic [WIDTH-1:0]   TimeoutLast = WIDTH'(TIMEOUT - 1);
  localparam logic [StreakW-1:0] LockCnt     = StreakW'(LOCK_COUNT);

  typedef enum logic {
    StIdle,
    StMeasure
  } state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_sync_d;
  logic [WIDTH-1:0]    r_cnt;
  logic [WIDTH-1:0]    w_cnt_d;
  logic [WIDTH-1:0]    r_high_next;
  logic [WIDTH-1:0]    w_high_next_d;
  logic [WIDTH-1:0]    r_period;
  logic [WIDTH-1:0]    w_period_d;
  logic [WIDTH-1:0]    r_high_time;
  logic [WIDTH-1:0]    w_high_time_d;
  logic                r_meas_valid;
  logic                w_meas_valid_d;
  logic                r_locked;
  logic                w_locked_d;
  logic                r_timeout;
  logic                w_timeout_d;
  logic [7:0]          r_err_count;
  logic [7:0]          w_err_count_d;
  logic [StreakW-1:0]  r_streak;
  logic [StreakW-1:0]  w_streak_d;

  logic                w_rise;
  logic                w_fall;
  logic [WIDTH-1:0]    w_cnt_inc;
  logic                w_in_tol;
  logic [StreakW-1:0]  w_streak_inc;
  logic [7:0]          w_err_inc;

  always_comb begin
    w_rise       = r_sync2 & ~r_sync_d;
    w_fall       = ~r_sync2 & r_sync_d;
    // Saturating increment; cnt+1 is also the length of the interval ending now.
    w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    w_in_tol     = (w_cnt_inc >= LoBound) && (w_cnt_inc <= HiBound);
    w_streak_inc = (r_streak >= LockCnt) ? r_streak : r_streak + 1'b1;
    w_err_inc    = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;
  end

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = w_cnt_inc;
    w_high_next_d  = r_high_next;
    w_period_d     = r_period;
    w_high_time_d  = r_high_time;
    w_meas_valid_d = 1'b0;
    w_locked_d     = r_locked;
    w_timeout_d    = r_timeout;
    w_err_count_d  = r_err_count;
    w_streak_d     = r_streak;

    unique case (r_state)
      StIdle: begin
        // First edge only arms the measurement; no period exists yet.
        if (w_rise) begin
          w_state_d   = StMeasure;
          w_cnt_d     = '0;
          w_timeout_d = 1'b0;
        end
      end
      StMeasure: begin
        if (w_rise) begin
          w_cnt_d        = '0;
          w_period_d     = w_cnt_inc;
          w_high_time_d  = r_high_next;
          w_meas_valid_d = 1'b1;
          if (w_in_tol) begin
            w_streak_d = w_streak_inc;
            if (w_streak_inc == LockCnt) begin
              w_locked_d = 1'b1;
            end
          end else begin
            w_streak_d    = '0;
            w_locked_d    = 1'b0;
            w_err_count_d = w_err_inc;
          end
        end else if (r_cnt >= TimeoutLast) begin
          w_state_d   = StIdle;
          w_timeout_d = 1'b1;
          w_locked_d  = 1'b0;
          w_streak_d  = '0;
        end else if (w_fall) begin
          w_high_next_d = w_cnt_inc;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync_d     <= 1'b0;
      r_cnt        <= '0;
      r_high_next  <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
      r_err_count  <= '0;
      r_streak     <= '0;
    end else begin
      r_state      <= w_state_d;
      r_sync1      <= clk_in;
      r_sync2      <= r_sync1;
      r_sync_d     <= r_sync2;
      r_cnt        <= w_cnt_d;
      r_high_next  <= w_high_next_d;
      r_period     <= w_period_d;
      r_high_time  <= w_high_time_d;
      r_meas_valid <= w_meas_valid_d;
      r_locked     <= w_locked_d;
      r_timeout    <= w_timeout_d;
      r_err_count  <= w_err_count_d;
      r_streak     <= w_streak_d;
    end
  end

  assign period     = r_period;
  assign high_time  = r_high_time;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign timeout    = r_timeout;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter with scaled-down parameters; a rise-level model
// predicts every measurement, lock state and error count.
module tb_clock_period_meter;

  localparam int W    = 16;
  localparam int EXP  = 100;
  localparam int TOLR = 2;
  localparam int LCK  = 4;
  localparam int TMO  = 200;

  typedef struct packed {
    logic [W-1:0] period;
    logic [W-1:0] high;
    logic         locked;
    logic [7:0]   err;
  } meas_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         clk_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         locked;
  logic         timeout;
  logic [7:0]   err_count;

  int n_tests = 0;
  int n_fail  = 0;

  meas_t exp_q[$];
  meas_t obs_q[$];

  // Model state: what the meter should believe after each rise.
  bit m_armed  = 0;
  int m_streak = 0;
  bit m_locked = 0;
  int m_err    = 0;
  int prev_p   = 0;
  int prev_h   = 0;

  clock_period_meter #(
    .WIDTH     (W),
    .EXPECTED  (EXP),
    .TOL       (TOLR),
    .LOCK_COUNT(LCK),
    .TIMEOUT   (TMO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clk_in    (clk_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .locked    (locked),
    .timeout   (timeout),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset && meas_valid === 1'b1) begin
      meas_t o;
      o.period = period;
      o.high   = high_time;
      o.locked = locked;
      o.err    = err_count;
      obs_q.push_back(o);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_rise(input int p, input int h);
    meas_t e;
    if (m_armed) begin
      if (prev_p >= EXP - TOLR && prev_p <= EXP + TOLR) begin
        if (m_streak < LCK) m_streak++;
        if (m_streak == LCK) m_locked = 1;
      end else begin
        m_streak = 0;
        m_locked = 0;
        if (m_err < 255) m_err++;
      end
      e.period = W'(prev_p);
      e.high   = W'(prev_h);
      e.locked = m_locked;
      e.err    = 8'(m_err);
      exp_q.push_back(e);
    end
    m_armed = 1;
    prev_p  = p;
    prev_h  = h;
  endtask

  task automatic model_stall();
    m_armed  = 0;
    m_streak = 0;
    m_locked = 0;
  endtask

  // One full clk_in cycle: rise at the first posedge, fall after h, next rise after p.
  task automatic drive_period(input int p, input int h);
    @(posedge clock);
    clk_in = 1'b1;
    model_rise(p, h);
    repeat (h) @(posedge clock);
    clk_in = 1'b0;
    repeat (p - h - 1) @(posedge clock);
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    clk_in = 1'b0;
    repeat (3) @(posedge clock);
    n_tests++; if (period !== '0) begin n_fail++; $display("FAIL reset_period: got %0d want 0", period); end
    n_tests++; if (high_time !== '0) begin n_fail++; $display("FAIL reset_high: got %0d want 0", high_time); end
    n_tests++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", meas_valid); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", err_count); end
    reset = 1'b1;
    repeat (3) @(posedge clock);
  endtask

  task automatic test_lock();
    meas_t e, o;
    repeat (6) drive_period(EXP, EXP / 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL lock_meas: no meas_valid, want period %0d", e.period);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL lock_meas: got p=%0d h=%0d lk=%0d err=%0d want p=%0d h=%0d lk=%0d err=%0d",
                   o.period, o.high, o.locked, o.err, e.period, e.high, e.locked, e.err);
        end
      end
    end
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL lock_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked: got %b want 1", locked); end
    n_tests++; if (period !== W'(EXP)) begin n_fail++; $display("FAIL lock_period: got %0d want %0d", period, EXP); end
    n_tests++; if (high_time !== W'(EXP / 2)) begin n_fail++; $display("FAIL lock_high: got %0d want %0d", high_time, EXP / 2); end
    n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL lock_err: got %0d want 0", err_count); end
  endtask

  task automatic test_drift();
    meas_t e, o;
    drive_period(EXP + 10, (EXP + 10) / 2);
    repeat (5) drive_period(EXP, EXP / 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL drift_meas: no meas_valid, want period %0d", e.period);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL drift_meas: got p=%0d h=%0d lk=%0d err=%0d want p=%0d h=%0d lk=%0d err=%0d",
                   o.period, o.high, o.locked, o.err, e.period, e.high, e.locked, e.err);
        end
      end
    end
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL drift_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL drift_relock: got %b want 1", locked); end
    n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL drift_err: got %0d want 1", err_count); end
  endtask

  task automatic test_boundary();
    meas_t e, o;
    int bnd[6] = '{EXP - TOLR, EXP + TOLR, EXP - TOLR, EXP + TOLR, EXP - TOLR - 1, EXP + TOLR + 1};
    int p;
    foreach (bnd[i]) drive_period(bnd[i], 10 + i * 7);
    for (int i = 0; i < 20; i++) begin
      p = int'($urandom_range(EXP + 6, EXP - 6));
      drive_period(p, int'($urandom_range(p - 10, 10)));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL bound_meas: no meas_valid, want period %0d", e.period);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL bound_meas: got p=%0d h=%0d lk=%0d err=%0d want p=%0d h=%0d lk=%0d err=%0d",
                   o.period, o.high, o.locked, o.err, e.period, e.high, e.locked, e.err);
        end
      end
    end
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL bound_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    n_tests++; if (err_count !== 8'(m_err)) begin n_fail++; $display("FAIL bound_err: got %0d want %0d", err_count, m_err); end
  endtask

  task automatic test_timeout();
    meas_t e, o;
    repeat (5) drive_period(EXP, EXP / 2);
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL tmo_prelock: got %b want 1", locked); end
    // Last rise, then clk_in parks low.
    @(posedge clock);
    clk_in = 1'b1;
    model_rise(0, 0);
    for (int i = 1; i <= TMO + 3; i++) begin
      @(posedge clock);
      if (i == EXP / 2) clk_in = 1'b0;
      if (i == TMO + 2) begin
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", timeout); end
      end
      if (i == TMO + 3) begin
        n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b want 1", timeout); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL tmo_locked: got %b want 0", locked); end
      end
    end
    model_stall();
    repeat (20) @(posedge clock);
    drive_period(EXP, EXP / 2);
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b want 0", timeout); end
    repeat (2) drive_period(EXP, EXP / 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL tmo_meas: no meas_valid, want period %0d", e.period);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL tmo_meas: got p=%0d h=%0d lk=%0d err=%0d want p=%0d h=%0d lk=%0d err=%0d",
                   o.period, o.high, o.locked, o.err, e.period, e.high, e.locked, e.err);
        end
      end
    end
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL tmo_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid();
    meas_t e, o;
    drive_period(EXP, EXP / 2);
    @(posedge clock);
    clk_in = 1'b1;
    model_rise(EXP, EXP / 2);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock);
      if (i == EXP / 2) clk_in = 1'b0;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL rmid_meas: no meas_valid, want period %0d", e.period);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL rmid_meas: got p=%0d h=%0d lk=%0d err=%0d want p=%0d h=%0d lk=%0d err=%0d",
                   o.period, o.high, o.locked, o.err, e.period, e.high, e.locked, e.err);
        end
      end
    end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (period !== '0) begin n_fail++; $display("FAIL rmid_period: got %0d want 0", period); end
    n_tests++; if (high_time !== '0) begin n_fail++; $display("FAIL rmid_high: got %0d want 0", high_time); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rmid_locked: got %b want 0", locked); end
    n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rmid_err: got %0d want 0", err_count); end
    n_tests++; if (timeout !== 1'b0 || meas_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_flags: got tmo=%b mv=%b want 0 0", timeout, meas_valid);
    end
    m_armed = 0; m_streak = 0; m_locked = 0; m_err = 0;
    repeat (3) @(posedge clock);
    reset = 1'b1;
    drive_period(EXP, EXP / 2);
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rmid_first: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
    drive_period(EXP, 37);
    drive_period(EXP, EXP / 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL rmid_meas2: no meas_valid, want period %0d", e.period);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL rmid_meas2: got p=%0d h=%0d lk=%0d err=%0d want p=%0d h=%0d lk=%0d err=%0d",
                   o.period, o.high, o.locked, o.err, e.period, e.high, e.locked, e.err);
        end
      end
    end
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rmid_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_saturate();
    meas_t e, o;
    int bad_lock = 0;
    repeat (260) drive_period(80, 40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL sat_meas: no meas_valid, want period %0d", e.period);
      end else begin
        o = obs_q.pop_front();
        if (o.locked === 1'b1 && e.period == W'(80)) bad_lock++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL sat_meas: got p=%0d h=%0d lk=%0d err=%0d want p=%0d h=%0d lk=%0d err=%0d",
                   o.period, o.high, o.locked, o.err, e.period, e.high, e.locked, e.err);
        end
      end
    end
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL sat_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    n_tests++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_err: got %0d want 255", err_count); end
    n_tests++; if (bad_lock != 0) begin n_fail++; $display("FAIL sat_locked: got %0d locked pulses want 0", bad_lock); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL sat_locked_end: got %b want 0", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_drift();
    test_boundary();
    test_timeout();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Measures a slow, divided clock (e.g. the 1 ms tick derived from the 50 MHz board clock) in units of system-clock cycles.
- Synchronizes the incoming clock, detects its edges, and reports the period and high time of each cycle.
- Raises a lock flag when the measured period matches the expected divide factor, and flags a timeout when the input stops toggling.
- Sits downstream of the divider as its checker/consumer. Used for on-board self-test and to gate timing logic until the ms tick is stable.

Parameters:
- WIDTH, 32, width of period/high-time counters and outputs.
- EXPECTED, 50000, nominal period in system cycles.
- TOL, 2, allowed deviation: a period passes when EXPECTED-TOL <= period <= EXPECTED+TOL.
- LOCK_COUNT, 4, consecutive in-tolerance periods required to assert locked.
- TIMEOUT, 100000, system cycles without a rising edge before declaring timeout.

Ports:
- clock, input, 1, system clock. All state updates occur on the falling edge.
- reset, input, 1, asynchronous, active-low reset.
- clk_in, input, 1, measured clock. Asynchronous to clock.
- period, output, WIDTH, last measured rising-to-rising interval in cycles.
- high_time, output, WIDTH, last measured rising-to-falling interval in cycles.
- meas_valid, output, 1, one-cycle pulse when period/high_time update.
- locked, output, 1, input period stable and in tolerance.
- timeout, output, 1, no rising edge within TIMEOUT cycles.
- err_count, output, 8, count of out-of-tolerance periods, saturating.

Behaviour:
- Reset (async, reset=0): all outputs 0; internal counters 0; synchronizer flops 0; FSM enters IDLE. Reset asserted mid-measurement discards any partial count.
- Synchronizer: 2-flop chain on clk_in, then one registered copy for edge detection.
  - rise = sync & ~sync_d; fall = ~sync & sync_d.
  - rise and fall are mutually exclusive by construction.
- Cycle counter cnt:
  - Cleared to 0 in the cycle rise is detected.
  - Otherwise increments by 1 each cycle and saturates at 2^WIDTH-1 (no wrap).
- FSM states:
  - IDLE: waiting for the first rising edge. fall is ignored. On rise -> MEASURE, clear cnt, no meas_valid.
  - MEASURE:
    - On fall: high_time_next <= cnt+1, held internally until the next period completes.
    - On rise: period <= cnt+1, high_time <= high_time_next, meas_valid=1 for exactly one cycle, cnt <= 0, remain in MEASURE.
    - If cnt reaches TIMEOUT-1 with no rise: -> IDLE, timeout <= 1, locked <= 0, lock streak <= 0. period and high_time hold their last values.
- timeout clears on the next detected rise (the IDLE->MEASURE transition).
- Latency: meas_valid asserts 3 clock edges after clk_in rises (2 synchronizer flops plus the detect/register stage); jitter is at most 1 cycle.
- Tolerance check runs on each completed period, in the same cycle period is loaded:
  - In tolerance: streak increments, saturating at LOCK_COUNT. locked <= 1 when streak reaches LOCK_COUNT.
  - Out of tolerance: streak <= 0, locked <= 0, err_count increments, saturating at 255.
- The first rise after reset or timeout never produces a measurement or a tolerance check.
- period and high_time change only with meas_valid and hold otherwise.
- No handshake; meas_valid is a strobe and consumers must sample it in that cycle.

Test Plan:
- Reset then drive clk_in with period 50000 cycles and high time 25000 for 6 periods:
  - No meas_valid on the first rise.
  - 5 pulses with period=50000 and high_time=25000.
  - locked=1 after the 4th measurement; err_count=0.
- Locked at 50000, then one period of 50010: that meas_valid shows period=50010, locked drops to 0, err_count=1. Return to 50000 and confirm relock after 4 further measurements.
- Boundary tolerance: periods of 49998 and 50002 count toward lock; 49997 and 50003 each increment err_count.
- Stop clk_in, holding it low, while locked:
  - timeout=1 and locked=0 exactly TIMEOUT cycles after the last rise was detected; no meas_valid.
  - Restart clk_in: timeout clears on the first rise, and the first meas_valid arrives on the second rise.
- Assert reset mid-period (cnt around 20000) and release:
  - All outputs are 0 immediately, asynchronously.
  - The next rise produces no measurement; the rise after it reports the correct full period.
- Drive 260 periods of 40000: err_count saturates at 255 with no wrap, and locked stays 0 throughout.
